tmds_encoder_multi: RTL

//  Parametrised multi-channel TMDS 8b/10b encoder; successor to the fixed 3-channel
//  DVI encoder datapath. Takes per-channel pixel bytes plus control bits and emits
//  10-bit parallel symbols per channel to the existing 10:1 serialiser (pixelclk5x domain).

---
 rtl/tmds_encoder_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi: NUM_CH-lane TMDS 8b/10b encoder with per-lane running disparity.
// Define TMDS_GUARD_BAND_EN to add HDMI video guard band (latency 4 instead of 2).
module tmds_encoder_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                 pixelclk,
  input  logic                 rst,
  input  logic                 de,
  input  logic [8*NUM_CH-1:0]  din,
  input  logic [2*NUM_CH-1:0]  ctl,
  output logic [10*NUM_CH-1:0] tmds_sym,
  output logic                 de_out,
  output logic [2*NUM_CH-1:0]  ctl_out
);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef struct packed {
    logic                   de;
    logic [2*NUM_CH-1:0]    ctl;
    logic [NUM_CH-1:0][8:0] qm;
    logic [NUM_CH-1:0][3:0] n1q;
  } stage_t;

  // Transition-minimising first step: XNOR chain when the byte is ones-heavy.
  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = 4'($countones(d));
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    unique case (c)
      2'b00:   t = TOK_00;
      2'b01:   t = TOK_01;
      2'b10:   t = TOK_10;
      default: t = TOK_11;
    endcase
    return t;
  endfunction

  stage_t                       s1_d, s1_q, enc;
  logic [NUM_CH-1:0][9:0]       sym_d, sym_q;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic                         de_q;
  logic [2*NUM_CH-1:0]          ctl_q;

  always_comb begin
    s1_d     = '0;
    s1_d.de  = de;
    s1_d.ctl = ctl;
    for (int k = 0; k < NUM_CH; k++) begin
      s1_d.qm[k]  = min_trans(din[8*k +: 8]);
      s1_d.n1q[k] = 4'($countones(s1_d.qm[k][7:0]));
    end
  end

`ifdef TMDS_GUARD_BAND_EN
  localparam logic [9:0] GB_CH1   = 10'b0100110011;
  localparam logic [9:0] GB_OTHER = 10'b1011001100;

  // Two extra stages let the encoder see de for the next two output cycles.
  stage_t d1_q, d2_q;
  logic   guard_go;

  always_ff @(posedge pixelclk) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= s1_q;
      d2_q <= d1_q;
    end
  end

  assign enc      = d2_q;
  assign guard_go = !d2_q.de && (d1_q.de || s1_q.de);
`else
  assign enc = s1_q;
`endif

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sym_d = '0;
    cnt_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [8:0]       qm;
      logic [CNT_W-1:0] cnt, diff;
      logic             cnt_pos, cnt_neg;
      qm      = enc.qm[k];
      cnt     = cnt_q[k];
      // diff = n1q - n0q = 2*n1q - 8, kept as modular two's complement
      diff    = CNT_W'({enc.n1q[k], 1'b0}) - CNT_W'(8);
      cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
      cnt_neg = cnt[CNT_W-1];
      if (!enc.de) begin
        sym_d[k] = ctl_token(enc.ctl[2*k +: 2]);
        cnt_d[k] = '0;
`ifdef TMDS_GUARD_BAND_EN
        if (guard_go) sym_d[k] = (k == 1) ? GB_CH1 : GB_OTHER;
`endif
      end else if ((cnt == '0) || (enc.n1q[k] == 4'd4)) begin
        sym_d[k] = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_d[k] = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if ((cnt_pos && (enc.n1q[k] > 4'd4)) || (cnt_neg && (enc.n1q[k] < 4'd4))) begin
        sym_d[k] = {1'b1, qm[8], ~qm[7:0]};
        cnt_d[k] = cnt + CNT_W'({qm[8], 1'b0}) - diff;
      end else begin
        sym_d[k] = {1'b0, qm[8], qm[7:0]};
        cnt_d[k] = cnt + diff - (qm[8] ? CNT_W'(0) : CNT_W'(2));
      end
    end
  end

  // NOTE: registers use <= so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge pixelclk) begin
    if (rst) begin
      s1_q  <= '0;
      sym_q <= {NUM_CH{TOK_00}};
      cnt_q <= '0;
      de_q  <= 1'b0;
      ctl_q <= '0;
    end else begin
      s1_q  <= s1_d;
      sym_q <= sym_d;
      cnt_q <= cnt_d;
      de_q  <= enc.de;
      ctl_q <= enc.ctl;
    end
  end

  assign tmds_sym = sym_q;
  assign de_out   = de_q;
  assign ctl_out  = ctl_q;

endmodule
